// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared state codes and handshake encodings for the divide sequencer
package div_seq_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  // Stall-request encoding consumed by ctrl.
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

endpackage

// File: rtl/div_seq_step.sv
// rtl/div_seq_step.sv - one combinational restoring-divide step
module div_step #(
  parameter int DW = 32
) (
  input  logic [DW:0]   r_i,
  input  logic          dividend_bit_i,
  input  logic [DW-1:0] divisor_i,
  output logic [DW:0]   r_o,
  output logic          q_bit_o
);

  logic [DW:0] shifted;
  logic [DW:0] divisor_ext;

  // The held remainder is always below the divisor, so its top bit is zero.
  logic unused_r_msb;
  assign unused_r_msb = r_i[DW];

  always_comb begin
    shifted     = {r_i[DW-1:0], dividend_bit_i};
    divisor_ext = {1'b0, divisor_i};
    q_bit_o     = (shifted >= divisor_ext);
    r_o         = q_bit_o ? (shifted - divisor_ext) : shifted;
  end

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle DIV/DIVU sequencer returning {remainder, quotient}
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DW   = 32,
  parameter int CNTW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            annul_i,
  input  logic            signed_div_i,
  input  logic [DW-1:0]   opdata1_i,
  input  logic [DW-1:0]   opdata2_i,
  output logic [2*DW-1:0] result_o,
  output logic            ready_o,
  output logic            stallreq_o
);

  div_state_e      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   dividend_q, dividend_d;
  logic [DW-1:0]   divisor_q, divisor_d;
  logic [DW-1:0]   quot_q, quot_d;
  logic [DW:0]     rem_q, rem_d;
  logic            s1_q, s1_d;
  logic            s2_q, s2_d;
  logic [2*DW-1:0] result_q, result_d;
  logic            ready_q, ready_d;

  logic [DW:0]     step_rem;
  logic            step_q_bit;
  logic [DW-1:0]   quot_fin;
  logic [DW-1:0]   rem_fin;

  logic unused_rem_msb;
  assign unused_rem_msb = rem_q[DW];

  div_step #(
    .DW(DW)
  ) u_step (
    .r_i           (rem_q),
    .dividend_bit_i(dividend_q[DW-1]),
    .divisor_i     (divisor_q),
    .r_o           (step_rem),
    .q_bit_o       (step_q_bit)
  );

  // Magnitudes were divided; restore signs so the remainder follows the dividend.
  assign quot_fin = (s1_q ^ s2_q) ? -quot_q : quot_q;
  assign rem_fin  = s1_q ? -rem_q[DW-1:0] : rem_q[DW-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    result_d   = result_q;
    ready_d    = ready_q;

    unique case (state_q)
      DivFree: begin
        ready_d  = DivResultNotReady;
        result_d = '0;
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            s1_d       = signed_div_i & opdata1_i[DW-1];
            s2_d       = signed_div_i & opdata2_i[DW-1];
            dividend_d = s1_d ? -opdata1_i : opdata1_i;
            divisor_d  = s2_d ? -opdata2_i : opdata2_i;
            quot_d     = '0;
            rem_d      = '0;
            cnt_d      = '0;
            state_d    = DivOn;
          end
        end
      end

      DivByZero: begin
        result_d = '0;
        ready_d  = DivResultReady;
        state_d  = DivEnd;
      end

      DivOn: begin
        if (annul_i) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
          cnt_d    = '0;
        end else if (cnt_q < CNTW'(DW)) begin
          rem_d      = step_rem;
          quot_d     = {quot_q[DW-2:0], step_q_bit};
          dividend_d = {dividend_q[DW-2:0], 1'b0};
          cnt_d      = cnt_q + CNTW'(1);
        end else begin
          result_d = {rem_fin, quot_fin};
          ready_d  = DivResultReady;
          state_d  = DivEnd;
        end
      end

      DivEnd: begin
        if (start_i == DivStop || annul_i) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
          cnt_d    = '0;
        end
      end

      default: begin
        state_d  = DivFree;
        ready_d  = DivResultNotReady;
        result_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = (start_i == DivStart && !annul_i && ready_q == DivResultNotReady) ? Stop : NoStop;

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - randomized self-checking bench for div_seq against an arithmetic model
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  div_seq #(
    .DW  (32),
    .CNTW(6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .annul_i     (annul_i),
    .signed_div_i(signed_div_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .stallreq_o  (stallreq_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected-transaction record: result visible from tx_rdy up to (not including) tx_end.
  bit          tx_active = 1'b0;
  int          tx_rdy = 0;
  int          tx_end = 0;
  logic [63:0] tx_res = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  initial begin
    bit exp_rdy;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_rdy = tx_active && (cyc >= tx_rdy) && (cyc < tx_end);
      check("ready_o", {63'h0, ready_o}, {63'h0, exp_rdy});
      check("result_o", result_o, exp_rdy ? tx_res : 64'h0);
      check("stallreq_o", {63'h0, stallreq_o}, {63'h0, start_i & ~annul_i & ~exp_rdy});
    end
  end

  task automatic launch(input bit s, input logic [31:0] a, input logic [31:0] b, input bit expect_result);
    @(posedge clk); #1;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    tx_res       = model(s, a, b);
    tx_rdy       = cyc + ((b == 32'h0) ? 2 : 34);
    tx_end       = 32'h7fffffff;
    tx_active    = expect_result;
  endtask

  task automatic scramble_ops();
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = 1'($urandom_range(0, 1));
  endtask

  task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b, input int hold);
    int lat;
    lat = (b == 32'h0) ? 2 : 34;
    launch(s, a, b, 1'b1);
    for (int i = 0; i < lat + 1 + hold; i++) begin
      @(posedge clk); #1;
      scramble_ops();
    end
    start_i = 1'b0;
    tx_end  = cyc + 1;
    @(posedge clk); #1;
    tx_active = 1'b0;
  endtask

  task automatic run_annul(input bit s, input logic [31:0] a, input logic [31:0] b);
    launch(s, a, b, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      scramble_ops();
    end
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic run_reset(input bit s, input logic [31:0] a, input logic [31:0] b);
    launch(s, a, b, 1'b0);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      scramble_ops();
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst     = 1'b0;
    start_i = 1'b0;
    check("rst_ready", {63'h0, ready_o}, 64'h0);
    check("rst_result", result_o, 64'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bit          s;
    logic [31:0] a, b;
    int          sel;

    rst          = 1'b1;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    idle(3);
    check("reset_ready", {63'h0, ready_o}, 64'h0);
    check("reset_result", result_o, 64'h0);
    rst = 1'b0;

    check("model_u_100_7", model(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
    check("model_s_m7_2", model(1'b1, 32'hFFFFFFF9, 32'h2), 64'hFFFFFFFF_FFFFFFFD);
    check("model_s_7_m2", model(1'b1, 32'h7, 32'hFFFFFFFE), 64'h00000001_FFFFFFFD);
    check("model_s_min_m1", model(1'b1, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);
    check("model_u_max_1", model(1'b0, 32'hFFFFFFFF, 32'h1), 64'h00000000_FFFFFFFF);
    check("model_u_20_3", model(1'b0, 32'd20, 32'd3), 64'h00000002_00000006);
    check("model_s_small", model(1'b1, 32'hFFFFFFFB, 32'd9), 64'hFFFFFFFB_00000000);

    run_div(1'b0, 32'd100, 32'd7, 0);
    run_div(1'b1, 32'hFFFFFFF9, 32'h2, 1);
    run_div(1'b1, 32'h7, 32'hFFFFFFFE, 0);
    run_div(1'b0, 32'h1234, 32'h0, 0);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 2);
    run_div(1'b0, 32'hFFFFFFFF, 32'h1, 0);
    run_div(1'b1, 32'hFFFFFFFB, 32'd9, 0);
    idle(1);
    run_annul(1'b0, 32'd50, 32'd3);
    run_div(1'b0, 32'd20, 32'd3, 0);
    run_reset(1'b1, 32'hFFFF0000, 32'd17);
    run_div(1'b0, 32'd20, 32'd3, 0);

    for (int k = 0; k < 24; k++) begin
      s   = 1'($urandom_range(0, 1));
      a   = $urandom;
      sel = $urandom_range(0, 5);
      if (sel == 5) a = 32'h80000000;
      case (sel)
        0:       b = 32'h0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFFFFFF;
        3:       b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if (b == 32'h0 && sel != 0) b = 32'h1;
      run_div(s, a, b, $urandom_range(0, 3));
      idle($urandom_range(0, 2));
    end

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle divide sequencer for the EX stage.
- Accepts a DIV/DIVU request from ex and runs a 32-iteration restoring divide. It holds the pipeline via stallreq_o and returns {remainder, quotient} for HI/LO writeback.
- Owns operand latching, the FSM, the iteration counter and sign correction, so the single-cycle ALU is never occupied.

Parameters:
- DW, 32, operand width; also sets the iteration count.
- CNTW, 6, iteration counter width; must hold DW.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start_i  in  1  divide request; held by ex until the result is consumed.
- annul_i  in  1  cancel the operation (flush or exception).
- signed_div_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  in  DW  dividend; sampled only on acceptance.
- opdata2_i  in  DW  divisor; sampled only on acceptance.
- result_o  out  2*DW  {remainder[63:32], quotient[31:0]}.
- ready_o  out  1  result valid.
- stallreq_o  out  1  pipeline stall request to ctrl.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=FREE, cnt=0, result_o=0, ready_o=0.
  - All internal operand registers are cleared.
  - Reset wins over every other input, including mid-operation.
- States: FREE, BYZERO, ON, END. All four are registered.
- FREE:
  - start_i=1 and annul_i=0 with divisor==0: go to BYZERO.
  - start_i=1 and annul_i=0 with divisor!=0: latch operands, go to ON, cnt=0.
  - Signed latch: record s1=dividend[31] and s2=divisor[31]. Latch the absolute values (two's-complement negate when the sign bit is set).
  - Unsigned latch: s1=s2=0.
  - Otherwise stay in FREE; ready_o=0, result_o=0.
- BYZERO: result_o=0, ready_o=1 registered, go to END. The ready latency from acceptance is 2 cycles.
- ON, annul_i=1: go to FREE next edge; ready_o stays 0; partial results are discarded.
- ON, cnt<DW: one restoring step per cycle.
  - Partial remainder r is DW+1 bits. r' = {r[DW-1:0], next dividend bit (MSB first)}.
  - If r' >= divisor: r = r' - divisor and shift in quotient bit 1.
  - Else: r = r' and shift in quotient bit 0.
  - cnt++.
- ON, cnt==DW (finalisation cycle):
  - Quotient is negated if s1^s2; remainder is negated if s1.
  - Load result_o, set ready_o=1, go to END.
- Latency: with acceptance in cycle T, ready_o is first high in cycle T+34 (32 iteration cycles plus 1 finalisation cycle).
- END:
  - ready_o=1 and result_o stable while start_i=1.
  - start_i=0: go to FREE next edge; ready_o=0 and result_o=0 from the next cycle.
  - annul_i=1: go to FREE, same as start_i=0.
- stallreq_o = start_i & ~annul_i & ~ready_o (combinational). It is low in END, so ex writes HI/LO that cycle and deasserts start_i next.
- Arithmetic edge cases:
  - Signed 0x80000000 / 0xFFFFFFFF: q=0x80000000, r=0 (wrap, no trap).
  - Signed |divisor| > |dividend|: q=0, r=dividend.
- Operand changes on opdata*_i after acceptance are ignored.
- A new start_i is only honoured in FREE.

Decomposition:
- Shared defines/package:
  - DivFree, DivByZero, DivOn, DivEnd (2-bit state codes).
  - DivResultReady/DivResultNotReady, DivStart/DivStop.
  - The stall-request encoding used by ctrl.
- Sub-module div_step: a combinational single restoring step.
  - Inputs: r, next dividend bit, divisor.
  - Outputs: new r, quotient bit.
- div_seq keeps the FSM, counter, sign logic and result register.

Test Plan:
- Unsigned 100/7, start at T, held → stallreq_o=1 for T..T+33; at T+34 ready_o=1, result_o={0x00000002, 0x0000000E}, stallreq_o=0. Drop start at T+35 → ready_o=0 at T+36.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) → result_o={0xFFFFFFFF, 0xFFFFFFFD}. Also signed 7/-2 → {0x00000001, 0xFFFFFFFD}.
- Divide by zero, 0x1234/0 → BYZERO at T+1, ready_o=1 with result_o=0 at T+2.
- Signed 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}. Also unsigned 0xFFFFFFFF/1 → {0, 0xFFFFFFFF}.
- annul_i pulsed in the 10th ON cycle → FREE next edge, ready_o never asserts. Then a new start 20/3 → {2, 6} after 34 cycles.
- rst asserted mid-ON (cycle T+15) → next cycle state FREE, result_o=0, ready_o=0. Changing opdata*_i during ON in a separate run leaves the result unaffected.
